// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, field positions,
// sequencer state encoding, error codes and the opcode class bundle.
package instr_sequencer_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 6;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ERR_W   = 2;

  // Instruction field positions
  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RI_MSB = 11;
  localparam int unsigned RI_LSB = 6;
  localparam int unsigned RJ_MSB = 5;
  localparam int unsigned RJ_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LOAD = 4'h1;
  localparam logic [OP_W-1:0] OP_MOV  = 4'h2;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h3;
  localparam logic [OP_W-1:0] OP_HALT = 4'h4;
  localparam int unsigned     OP_ALU_BIT = 3;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DISPATCH,
    S_WAIT,
    S_ADVANCE,
    S_CHECK_RUN,
    S_HALT,
    S_ERR
  } seq_state_t;

  typedef struct packed {
    logic is_alu;
    logic is_load;
    logic is_mov;
    logic is_jmp;
    logic is_halt;
    logic is_nop;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational opcode classifier: exactly one class flag is set per opcode.
module instr_decode
  import instr_sequencer_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output op_class_t       cls_c
);

  always_comb begin
    cls_c = '0;
    if (op[OP_ALU_BIT]) begin
      cls_c.is_alu = 1'b1;
    end else begin
      case (op)
        OP_NOP:  cls_c.is_nop     = 1'b1;
        OP_LOAD: cls_c.is_load    = 1'b1;
        OP_MOV:  cls_c.is_mov     = 1'b1;
        OP_JMP:  cls_c.is_jmp     = 1'b1;
        OP_HALT: cls_c.is_halt    = 1'b1;
        default: cls_c.is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction fetch/dispatch controller: fetches, decodes, starts one execution
// unit per instruction, waits for its done, and steps or redirects the PC.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [OP_W-1:0]    opCode,
  output logic [REG_W-1:0]   Ri,
  output logic [REG_W-1:0]   Rj,
  output logic               alu_start,
  output logic               load_start,
  output logic               mov_start,
  input  logic               alu_done,
  input  logic               load_done,
  input  logic               mov_done,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [ERR_W-1:0]   err_code
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_t       state, state_nxt;
  op_class_t        dec_cls_c;
  op_class_t        cls_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             sel_done_c;

  logic latch_en_c;
  logic pc_inc_c;
  logic pc_jmp_c;
  logic cnt_clr_c;
  logic cnt_inc_c;
  logic set_halt_c;
  logic set_ill_c;
  logic set_to_c;

  // Classify the word arriving from memory so starts can be registered at LATCH
  instr_decode u_decode (
    .op    (imem_data[OP_MSB:OP_LSB]),
    .cls_c (dec_cls_c)
  );

  assign imem_addr = pc;

  // Only the unit that was dispatched is listened to
  always_comb begin
    sel_done_c = 1'b0;
    if (cls_q.is_alu)       sel_done_c = alu_done;
    else if (cls_q.is_load) sel_done_c = load_done;
    else if (cls_q.is_mov)  sel_done_c = mov_done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch_en_c = 1'b0;
    pc_inc_c   = 1'b0;
    pc_jmp_c   = 1'b0;
    cnt_clr_c  = 1'b0;
    cnt_inc_c  = 1'b0;
    set_halt_c = 1'b0;
    set_ill_c  = 1'b0;
    set_to_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        latch_en_c = 1'b1;
        state_nxt  = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (cls_q.is_alu || cls_q.is_load || cls_q.is_mov) begin
          cnt_clr_c = 1'b1;
          state_nxt = S_WAIT;
        end else if (cls_q.is_nop) begin
          state_nxt = S_ADVANCE;
        end else if (cls_q.is_jmp) begin
          pc_jmp_c  = 1'b1;
          state_nxt = S_CHECK_RUN;
        end else if (cls_q.is_halt) begin
          set_halt_c = 1'b1;
          state_nxt  = S_HALT;
        end else begin
          set_ill_c = 1'b1;
          state_nxt = S_ERR;
        end
      end
      S_WAIT: begin
        // done in the final allowed cycle still wins over the timeout
        if (sel_done_c) begin
          state_nxt = S_ADVANCE;
        end else if (wait_cnt == WAIT_LAST) begin
          set_to_c  = 1'b1;
          state_nxt = S_ERR;
        end else begin
          cnt_inc_c = 1'b1;
        end
      end
      S_ADVANCE: begin
        pc_inc_c  = 1'b1;
        state_nxt = S_CHECK_RUN;
      end
      S_CHECK_RUN: begin
        state_nxt = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_nxt = S_HALT;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Instruction fields and class, held until the next LATCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opCode <= '0;
      Ri     <= '0;
      Rj     <= '0;
      cls_q  <= '0;
    end else if (latch_en_c) begin
      opCode <= imem_data[OP_MSB:OP_LSB];
      Ri     <= imem_data[RI_MSB:RI_LSB];
      Rj     <= imem_data[RJ_MSB:RJ_LSB];
      cls_q  <= dec_cls_c;
    end
  end

  // Start pulses are registered at LATCH so they are high exactly during DISPATCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_start  <= 1'b0;
      load_start <= 1'b0;
      mov_start  <= 1'b0;
    end else begin
      alu_start  <= latch_en_c & dec_cls_c.is_alu;
      load_start <= latch_en_c & dec_cls_c.is_load;
      mov_start  <= latch_en_c & dec_cls_c.is_mov;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (pc_inc_c) begin
      pc <= pc + PC_W'(1);
    end else if (pc_jmp_c) begin
      pc <= PC_W'({Ri, Rj});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (cnt_clr_c) begin
      wait_cnt <= '0;
    end else if (cnt_inc_c) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Status flags; halted and error are sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      halted   <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      busy <= !(state_nxt inside {S_IDLE, S_HALT, S_ERR});
      if (set_halt_c) halted <= 1'b1;
      if (set_ill_c) begin
        error    <= 1'b1;
        err_code <= ERR_ILLEGAL;
      end else if (set_to_c) begin
        error    <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Top-level instruction fetch/dispatch controller for the simple CPU.
- Fetches 16-bit instructions from a synchronous instruction memory and decodes the opcode.
- Starts exactly one execution sub-FSM (ALU, load or move unit) per instruction and waits for that unit's done.
- Advances or redirects the PC, and handles NOP, JMP, HALT, illegal opcodes and unit timeouts.
- Sits above the per-instruction FSMs; the operand fields it drives are their opCode/Ri/Rj inputs.

Parameters:
- PC_W, 8, program counter width (legal range 1..12).
- TIMEOUT, 15, maximum number of WAIT cycles allowed for a unit's done before the error trap (legal range 1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- run  in  1  level; enables fetching new instructions.
- imem_addr  out  PC_W  instruction memory address; equals pc.
- imem_data  in  16  instruction word, valid one cycle after imem_addr is presented.
- opCode  out  4  latched instr[15:12].
- Ri  out  6  latched instr[11:6].
- Rj  out  6  latched instr[5:0].
- alu_start, load_start, mov_start  out  1 each  single-cycle start pulses.
- alu_done, load_done, mov_done  in  1 each  unit completion flags.
- pc  out  PC_W  current program counter.
- busy  out  1  high whenever the state is not IDLE, HALT or ERR.
- halted  out  1  sticky; set by the HALT opcode.
- error  out  1  sticky error flag.
- err_code  out  2  0 = none, 1 = illegal opcode, 2 = unit timeout.

Behaviour:
Reset and outputs
- Reset values (asynchronous): state IDLE; pc = 0; opCode/Ri/Rj = 0; all start outputs 0; busy, halted, error = 0; err_code = 0.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.

Opcode decode
- 0000 NOP.
- 0001 LOAD, executed by the load unit.
- 0010 MOV, executed by the move unit.
- 0011 JMP: target = {Ri,Rj}[PC_W-1:0].
- 0100 HALT.
- 0101, 0110, 0111: illegal.
- 1xxx: ALU; the ALU unit uses opCode[2:0] as the operation select.

State machine
- IDLE: if run = 1, go to FETCH; otherwise stay.
- FETCH: imem_addr = pc; go to LATCH.
- LATCH: capture imem_data into opCode/Ri/Rj; go to DISPATCH. opCode/Ri/Rj then hold stable until the next LATCH.
- DISPATCH, by opcode class:
  - ALU/LOAD/MOV: assert the matching start for exactly this one cycle; clear the timeout counter; go to WAIT.
  - NOP: go to ADVANCE.
  - JMP: pc <= target; go to CHECK_RUN.
  - HALT: set halted; go to HALT.
  - Illegal: error = 1, err_code = 1; go to ERR.
- WAIT:
  - Sample only the selected unit's done; the other units' done inputs are ignored.
  - done = 1: go to ADVANCE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT without done: error = 1, err_code = 2; go to ERR.
  - done arriving in the same cycle the counter reaches TIMEOUT counts as success.
- ADVANCE: pc <= pc + 1, wrapping modulo 2^PC_W; go to CHECK_RUN.
- CHECK_RUN: run = 1 goes to FETCH; run = 0 goes to IDLE.
  - run is sampled only here and in IDLE; deasserting run mid-instruction always completes that instruction.
- HALT and ERR are absorbing; only reset leaves them. No start pulses are issued in either state.

Timing
- Per-instruction period: NOP = 5 cycles, JMP = 4 cycles, unit instruction = 5 + N cycles.
  - N = unit latency, counted from the cycle after DISPATCH up to and including the done cycle.
  - With the 5-state ALU FSM, N = 5, so one ALU instruction takes 10 cycles.
- A done level still high in the cycle after the sequencer leaves WAIT is ignored, because done is sampled only in WAIT.
- Reset asserted mid-WAIT returns to IDLE immediately with all starts low. Units are reset by the same reset.

Decomposition:
- Shared package:
  - Opcode constants: OP_NOP, OP_LOAD, OP_MOV, OP_JMP, OP_HALT, and ALU class bit 3.
  - Sequencer state encoding.
  - err_code constants.
  - Instruction field positions: [15:12], [11:6], [5:0].
- One natural sub-module: instr_decode, a combinational classifier producing one-hot {is_alu, is_load, is_mov, is_jmp, is_halt, is_nop, is_illegal}. Everything else stays in instr_sequencer.

Test Plan:
- Program [0x8041 (ALU op 0, Ri 1, Rj 1), 0x4000 HALT], ALU model raises done 5 cycles after start:
  - alu_start is a single-cycle pulse with opCode = 8, Ri = 1, Rj = 1.
  - pc = 1 exactly 10 cycles after the first FETCH; then halted = 1, busy = 0, and pc stays 1.
- Program [0x3005 JMP to 5], with 0x0000 NOP at addresses 5 and 6 and 0x4000 HALT at 7:
  - Fetch address sequence 0, 5, 6, 7; halted = 1 at pc = 7.
- Opcode 0x6 at address 0:
  - No start pulse; error = 1, err_code = 1; state remains ERR until reset.
- LOAD issued with load_done never asserted, TIMEOUT = 15:
  - error = 1, err_code = 2 after exactly 15 WAIT cycles.
  - Second case: alu_done pulsed during the wait has no effect.
- run dropped during the 3rd WAIT cycle of an ALU instruction:
  - The instruction completes; pc increments to 1; state becomes IDLE and no further fetch occurs.
  - Reasserting run fetches address 1.
- Reset pulsed during WAIT:
  - All starts low, pc = 0, err_code = 0 immediately.
  - After release with run = 1, fetch restarts at address 0.
- With PC_W = 2, four NOPs at addresses 0..3:
  - pc wraps 3 -> 0 and execution continues.
